// File: rtl/router_pkg.sv
// Shared router definitions: data/address widths, header field layout and
// the reserved (invalid) destination address.
package router_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 2;

    // Header byte layout: [1:0] destination address, [7:2] payload length.
    localparam int unsigned HDR_ADDR_LSB = 0;
    localparam int unsigned HDR_ADDR_MSB = HDR_ADDR_LSB + ADDR_W - 1;
    localparam int unsigned HDR_LEN_LSB  = ADDR_W;
    localparam int unsigned HDR_LEN_MSB  = DATA_W - 1;

    // Address 3 has no output port; headers carrying it are dropped.
    localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;

    typedef logic [DATA_W-1:0] byte_t;

endpackage

// File: rtl/router_parity_acc.sv
// Packet parity accumulator: running XOR of header and payload bytes, capture
// of the packet's own parity byte, and the registered mismatch flag.
module router_parity_acc
    import router_pkg::*;
(
    input  logic  clk,
    input  logic  resetn,
    input  logic  clr,          // new packet starting
    input  logic  hdr_en,       // fold header into running parity
    input  byte_t hdr,
    input  logic  data_en,      // fold payload byte into running parity
    input  byte_t data_in,
    input  logic  pkt_par_en,   // capture the packet's parity byte
    input  logic  parity_done,
    output logic  err
);

    byte_t int_par_q;
    byte_t pkt_par_q;

    // Running XOR over header and accepted payload bytes.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            int_par_q <= '0;
        end else if (clr) begin
            int_par_q <= '0;
        end else if (hdr_en) begin
            int_par_q <= int_par_q ^ hdr;
        end else if (data_en) begin
            int_par_q <= int_par_q ^ data_in;
        end
    end

    // Parity byte as sent by the source.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            pkt_par_q <= '0;
        end else if (pkt_par_en) begin
            pkt_par_q <= data_in;
        end
    end

    // Compare only once the parity byte is in; result then sticks until the next packet.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            err <= 1'b0;
        end else if (clr) begin
            err <= 1'b0;
        end else if (parity_done) begin
            err <= (int_par_q != pkt_par_q);
        end
    end

endmodule

// File: rtl/router_pkt_reg.sv
// Router packet register: latches the header, steers bytes to the output FIFO
// (with a one-byte hold slot for a full FIFO) and tracks packet completion.
module router_pkt_reg
    import router_pkg::*;
(
    input  logic              clk,
    input  logic              resetn,
    input  logic              pkt_valid,
    input  logic [DATA_W-1:0] data_in,
    input  logic              fifo_full,
    input  logic              detect_add,
    input  logic              lfd_state,
    input  logic              ld_state,
    input  logic              laf_state,
    input  logic              full_state,
    input  logic              rst_int_reg,
    output logic [DATA_W-1:0] dout,
    output logic              parity_done,
    output logic              low_packet_valid,
    output logic              err
);

    byte_t             header_q;
    byte_t             hold_q;
    logic [ADDR_W-1:0] hdr_addr;
    logic              hdr_capture;
    logic              pd_set;

    assign hdr_addr    = data_in[HDR_ADDR_MSB:HDR_ADDR_LSB];
    assign hdr_capture = detect_add && pkt_valid && (hdr_addr != ADDR_INVALID);

    // Parity byte consumed either straight to the FIFO, or later out of the hold slot.
    assign pd_set = (ld_state && !fifo_full && !pkt_valid) ||
                    (laf_state && low_packet_valid && !parity_done);

    // Header latch; invalid-address headers leave the previous value untouched.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            header_q <= '0;
        end else if (hdr_capture) begin
            header_q <= data_in;
        end
    end

    // Byte that arrived while the FIFO was full, replayed in laf_state.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            hold_q <= '0;
        end else if (ld_state && fifo_full) begin
            hold_q <= data_in;
        end
    end

    // Output byte mux: header, live data, or the held byte.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            dout <= '0;
        end else if (lfd_state) begin
            dout <= header_q;
        end else if (ld_state && !fifo_full) begin
            dout <= data_in;
        end else if (laf_state) begin
            dout <= hold_q;
        end
    end

    // Packet-complete flag; a new header clears it even if a set coincides.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            parity_done <= 1'b0;
        end else if (detect_add) begin
            parity_done <= 1'b0;
        end else if (pd_set) begin
            parity_done <= 1'b1;
        end
    end

    // Source ended the packet; cleared by the FSM's internal-register reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            low_packet_valid <= 1'b0;
        end else if (rst_int_reg) begin
            low_packet_valid <= 1'b0;
        end else if (ld_state && !pkt_valid) begin
            low_packet_valid <= 1'b1;
        end
    end

    // Payload bytes seen in full_state are replays, so they are not folded in again.
    router_parity_acc u_parity_acc (
        .clk         (clk),
        .resetn      (resetn),
        .clr         (detect_add),
        .hdr_en      (lfd_state),
        .hdr         (header_q),
        .data_en     (ld_state && pkt_valid && !full_state),
        .data_in     (data_in),
        .pkt_par_en  (ld_state && !pkt_valid),
        .parity_done (parity_done),
        .err         (err)
    );

endmodule

// File: tb/tb_router_pkt_reg.sv
// Self-checking bench for router_pkt_reg: packet-level model checked every
// cycle, plus literal expectations for the directed scenarios.
module tb_router_pkt_reg;

    logic       clk = 1'b0;
    logic       resetn;
    logic       pkt_valid;
    logic [7:0] data_in;
    logic       fifo_full;
    logic       detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg;
    logic [7:0] dout;
    logic       parity_done, low_packet_valid, err;

    int checks = 0;
    int errors = 0;

    // FSM indication flags {detect_add, lfd, ld, laf, full, rst_int_reg}
    localparam logic [5:0] IDLE = 6'b000000;
    localparam logic [5:0] DA   = 6'b100000;
    localparam logic [5:0] LFD  = 6'b010000;
    localparam logic [5:0] LD   = 6'b001000;
    localparam logic [5:0] LAF  = 6'b000100;
    localparam logic [5:0] FULL = 6'b000010;
    localparam logic [5:0] RIR  = 6'b000001;

    router_pkt_reg dut (
        .clk              (clk),
        .resetn           (resetn),
        .pkt_valid        (pkt_valid),
        .data_in          (data_in),
        .fifo_full        (fifo_full),
        .detect_add       (detect_add),
        .lfd_state        (lfd_state),
        .ld_state         (ld_state),
        .laf_state        (laf_state),
        .full_state       (full_state),
        .rst_int_reg      (rst_int_reg),
        .dout             (dout),
        .parity_done      (parity_done),
        .low_packet_valid (low_packet_valid),
        .err              (err)
    );

    always #5 clk = ~clk;

    // Model state: expected outputs plus the list of bytes the packet parity covers.
    logic [7:0] m_dout, m_hdr, m_hold, m_ppar;
    logic       m_pd, m_lpv, m_err;
    logic       m_valid = 1'b0;
    logic [7:0] m_pq[$];

    function automatic logic [7:0] q_xor();
        logic [7:0] x = 8'h00;
        foreach (m_pq[i]) x = x ^ m_pq[i];
        return x;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Predict the state after the coming clock edge from the current inputs.
    task automatic model_step();
        logic [7:0] n_dout, n_hdr, n_hold, n_ppar;
        logic       n_pd, n_lpv, n_err;
        m_valid = 1'b1;
        if (!resetn) begin
            m_dout = 0; m_hdr = 0; m_hold = 0; m_ppar = 0;
            m_pd = 0; m_lpv = 0; m_err = 0;
            m_pq.delete();
            return;
        end
        n_err  = detect_add ? 1'b0 : (m_pd ? (q_xor() != m_ppar) : m_err);
        n_pd   = detect_add ? 1'b0 :
                 (((ld_state && !fifo_full && !pkt_valid) ||
                   (laf_state && m_lpv && !m_pd)) ? 1'b1 : m_pd);
        n_lpv  = rst_int_reg ? 1'b0 : ((ld_state && !pkt_valid) ? 1'b1 : m_lpv);
        n_dout = lfd_state ? m_hdr :
                 (ld_state && !fifo_full) ? data_in :
                 laf_state ? m_hold : m_dout;
        n_hold = (ld_state && fifo_full) ? data_in : m_hold;
        n_hdr  = (detect_add && pkt_valid && data_in[1:0] != 2'b11) ? data_in : m_hdr;
        n_ppar = (ld_state && !pkt_valid) ? data_in : m_ppar;
        if (detect_add) m_pq.delete();
        else if (lfd_state) m_pq.push_back(m_hdr);
        else if (ld_state && pkt_valid && !full_state) m_pq.push_back(data_in);
        m_dout = n_dout; m_hdr = n_hdr; m_hold = n_hold; m_ppar = n_ppar;
        m_pd = n_pd; m_lpv = n_lpv; m_err = n_err;
    endtask

    // Every-cycle comparison of all outputs against the model.
    always @(posedge clk) begin
        #1;
        if (m_valid) begin
            chk("dout", dout, m_dout);
            chk("parity_done", {7'b0, parity_done}, {7'b0, m_pd});
            chk("low_packet_valid", {7'b0, low_packet_valid}, {7'b0, m_lpv});
            chk("err", {7'b0, err}, {7'b0, m_err});
        end
    end

    task automatic cyc(input logic [5:0] st, input logic pv, input logic [7:0] din,
                       input logic ff);
        {detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg} = st;
        pkt_valid = pv;
        data_in   = din;
        fifo_full = ff;
        model_step();
        @(posedge clk);
        #2;
    endtask

    task automatic good_pkt(input logic [7:0] par, input logic exp_err);
        cyc(DA, 1, 8'h0D, 0);
        chk("hdr_cap", dut.header_q, 8'h0D);
        cyc(LFD, 1, 8'h11, 0);
        chk("lfd_dout", dout, 8'h0D);
        cyc(LD, 1, 8'h11, 0);
        chk("ld_dout_11", dout, 8'h11);
        cyc(LD, 1, 8'h22, 0);
        chk("ld_dout_22", dout, 8'h22);
        cyc(LD, 1, 8'h33, 0);
        chk("ld_dout_33", dout, 8'h33);
        cyc(LD, 0, par, 0);
        chk("par_dout", dout, par);
        chk("pd_set", {7'b0, parity_done}, 8'h01);
        cyc(RIR, 0, 8'h00, 0);
        chk("err_after_pd", {7'b0, err}, {7'b0, exp_err});
        chk("lpv_clr", {7'b0, low_packet_valid}, 8'h00);
        cyc(IDLE, 0, 8'h00, 0);
        chk("err_hold", {7'b0, err}, {7'b0, exp_err});
    endtask

    initial begin
        resetn = 1'b0;
        cyc(IDLE, 0, 8'h00, 0);
        chk("rst_dout", dout, 8'h00);
        resetn = 1'b1;

        // Good packet, then bad parity byte.
        good_pkt(8'h0D, 1'b0);
        good_pkt(8'h0E, 1'b1);
        cyc(IDLE, 0, 8'h00, 0);
        chk("err_sticky", {7'b0, err}, 8'h01);
        cyc(DA, 1, 8'h0D, 0);
        chk("err_clr_da", {7'b0, err}, 8'h00);

        // FIFO full while 0x22 is on the bus.
        cyc(LFD, 1, 8'h11, 0);
        cyc(LD, 1, 8'h11, 0);
        cyc(LD, 1, 8'h22, 1);
        chk("full_hold", dut.hold_q, 8'h22);
        chk("full_dout_kept", dout, 8'h11);
        cyc(FULL, 1, 8'h22, 1);
        cyc(LAF, 1, 8'h22, 0);
        chk("laf_dout", dout, 8'h22);
        cyc(LD, 1, 8'h33, 0);
        cyc(LD, 0, 8'h0D, 0);
        cyc(RIR, 0, 8'h00, 0);
        cyc(IDLE, 0, 8'h00, 0);
        chk("full_ipar", dut.u_parity_acc.int_par_q, 8'h0D);
        chk("full_err", {7'b0, err}, 8'h00);

        // FIFO full on the parity byte.
        cyc(DA, 1, 8'h0D, 0);
        cyc(LFD, 1, 8'h11, 0);
        cyc(LD, 1, 8'h11, 0);
        cyc(LD, 1, 8'h22, 0);
        cyc(LD, 1, 8'h33, 0);
        cyc(LD, 0, 8'h0D, 1);
        chk("lowpv_set", {7'b0, low_packet_valid}, 8'h01);
        chk("pd_wait", {7'b0, parity_done}, 8'h00);
        cyc(FULL, 0, 8'h0D, 1);
        cyc(LAF, 0, 8'h0D, 0);
        chk("laf_pd", {7'b0, parity_done}, 8'h01);
        chk("laf_par_dout", dout, 8'h0D);
        cyc(RIR, 0, 8'h00, 0);
        chk("lowpv_clr", {7'b0, low_packet_valid}, 8'h00);
        cyc(IDLE, 0, 8'h00, 0);
        chk("lowpv_err", {7'b0, err}, 8'h00);

        // Invalid address 3: header and dout stay put.
        cyc(DA, 1, 8'h0F, 0);
        chk("inv_hdr", dut.header_q, 8'h0D);
        chk("inv_dout", dout, 8'h0D);
        cyc(LFD, 1, 8'h00, 0);
        chk("inv_lfd", dout, 8'h0D);

        // Clear beats set on coincidence.
        cyc(DA | LD | RIR, 0, 8'h5A, 0);
        chk("clr_pd", {7'b0, parity_done}, 8'h00);
        chk("clr_lpv", {7'b0, low_packet_valid}, 8'h00);

        // Reset mid-packet, then a clean packet.
        cyc(DA, 1, 8'h0D, 0);
        cyc(LFD, 1, 8'h11, 0);
        cyc(LD, 1, 8'h11, 0);
        resetn = 1'b0;
        cyc(LD, 1, 8'h22, 1);
        chk("mid_rst_dout", dout, 8'h00);
        chk("mid_rst_hdr", dut.header_q, 8'h00);
        chk("mid_rst_hold", dut.hold_q, 8'h00);
        chk("mid_rst_ipar", dut.u_parity_acc.int_par_q, 8'h00);
        resetn = 1'b1;
        good_pkt(8'h0D, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
